// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front end.
// Channel FSM encoding, button index map and the default debounce window.
package calc_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  localparam int BTN_INC_A = 0;
  localparam int BTN_INC_B = 1;
  localparam int BTN_OP    = 2;
  localparam int BTN_EQ    = 3;
  localparam int BTN_CLR   = 4;

  localparam int N_BTN_DEFAULT           = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop sync, debounce FSM, registered level/press/release; DEBOUNCE_CYCLES+2 cycles raw-to-output.
// No backpressure: press/release are single-cycle strobes that downstream must take when they occur.
module debounce_channel
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  btn_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // cnt only advances while below CNT_MAX, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOW;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= HIGH;
            cnt         <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state         <= LOW;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Array of independent debounce channels for the calculator push-buttons; DEBOUNCE_CYCLES+2 cycles latency.
// No backpressure: outputs are registered levels and single-cycle press/release strobes.
module button_conditioner
  import calc_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, N_BTN=5.
// Expected pulse events are queued when stimulus is driven and matched as pulses appear.
module tb_button_conditioner;
  import calc_pkg::*;

  localparam int NB  = 5;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  button_conditioner #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } ev_t;

  ev_t           sb[$];
  int            e = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic          mon_en = 1'b0;
  logic [NB-1:0] exp_lvl = '0;

  always @(posedge clk) e++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int nxt();
    return e + 1;
  endfunction

  task automatic expect_evt(input int at, input logic [NB-1:0] p, input logic [NB-1:0] r);
    ev_t ev;
    ev.cyc   = at;
    ev.press = p;
    ev.rel   = r;
    sb.push_back(ev);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if ((btn_press | btn_release) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {btn_press, btn_release}, 32'd0);
        end else begin
          ev_t ev;
          ev = sb.pop_front();
          chk("pulse_edge", e, ev.cyc);
          chk("press", btn_press, ev.press);
          chk("release", btn_release, ev.rel);
          exp_lvl = (exp_lvl | ev.press) & ~ev.rel;
        end
      end else if (sb.size() != 0 && sb[0].cyc < e) begin
        chk("missing_pulse", e, sb[0].cyc);
        void'(sb.pop_front());
      end
      chk("level", btn_level, exp_lvl);
    end
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    tick(3);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_release", btn_release, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(20);
    chk("idle_state0", 32'(dut.g_ch[0].u_ch.state), 32'(LOW));
    chk("idle_state1", 32'(dut.g_ch[1].u_ch.state), 32'(LOW));
    chk("idle_state2", 32'(dut.g_ch[2].u_ch.state), 32'(LOW));
    chk("idle_state3", 32'(dut.g_ch[3].u_ch.state), 32'(LOW));
    chk("idle_state4", 32'(dut.g_ch[4].u_ch.state), 32'(LOW));
    chk("idle_level", btn_level, 0);

    // Clean press then release on channel 0.
    btn_raw[0] = 1'b1;
    expect_evt(nxt() + LAT, 5'b00001, 5'b00000);
    tick(20);
    btn_raw[0] = 1'b0;
    expect_evt(nxt() + LAT, 5'b00000, 5'b00001);
    tick(12);

    // Channel 1: runs of DC highs are rejected, DC+1 highs are accepted.
    btn_raw[1] = 1'b1; tick(4);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(4);
    btn_raw[1] = 1'b0; tick(2);
    chk("glitch_level1", btn_level[1], 0);
    btn_raw[1] = 1'b1;
    expect_evt(nxt() + LAT, 5'b00010, 5'b00000);
    tick(5);
    btn_raw[1] = 1'b0;
    expect_evt(nxt() + LAT, 5'b00000, 5'b00010);
    tick(12);

    // Channel 2 chatters every cycle: nothing should come out.
    for (int i = 0; i < 50; i++) begin
      btn_raw[2] = ~btn_raw[2];
      tick(1);
    end
    tick(10);
    chk("chatter_level2", btn_level[2], 0);

    // Channels 3 and 4 together, released 3 cycles apart.
    btn_raw[4:3] = 2'b11;
    expect_evt(nxt() + LAT, 5'b11000, 5'b00000);
    tick(10);
    btn_raw[3] = 1'b0;
    expect_evt(nxt() + LAT, 5'b00000, 5'b01000);
    tick(3);
    btn_raw[4] = 1'b0;
    expect_evt(nxt() + LAT, 5'b00000, 5'b10000);
    tick(12);

    // Reset while channel 4 is held high and channel 0 is mid-debounce.
    btn_raw[4] = 1'b1;
    expect_evt(nxt() + LAT, 5'b10000, 5'b00000);
    tick(10);
    btn_raw[0] = 1'b1;
    tick(4);
    chk("pre_rst_state0", 32'(dut.g_ch[0].u_ch.state), 32'(WAIT_HIGH));
    #1;
    rst_n   = 1'b0;
    exp_lvl = '0;
    #1;
    chk("async_rst_level", btn_level, 0);
    chk("async_rst_press", btn_press, 0);
    chk("async_rst_release", btn_release, 0);
    chk("async_rst_state0", 32'(dut.g_ch[0].u_ch.state), 32'(LOW));
    tick(2);
    rst_n = 1'b1;
    expect_evt(nxt() + LAT, 5'b10001, 5'b00000);
    tick(12);

    chk("sb_empty", sb.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
